// File: rtl/bridge_arb_pkg.sv
// Shared types and defaults for the DRAM bridge arbiter.
package bridge_arb_pkg;

    localparam int unsigned ARB_ADDR_W = 8;
    localparam int unsigned ARB_DATA_W = 64;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_e;

    typedef struct packed {
        logic                  r_wb;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] data_w;
    } bridge_cmd_t;

    // Round-robin successor of idx among n slots.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    assign o_any = |i_req;

    always_comb begin
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing a single-outstanding DRAM bridge between NUM_REQ requesters.
module bridge_arbiter
    import bridge_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = ARB_ADDR_W,
    parameter int unsigned DATA_W  = ARB_DATA_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_r_wb,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_w,
    output logic [NUM_REQ-1:0]             req_grant,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]              rsp_data,
    output logic                           C_in_valid,
    output logic                           C_r_wb,
    output logic [ADDR_W-1:0]              C_addr,
    output logic [DATA_W-1:0]              C_data_w,
    input  logic                           C_out_valid,
    input  logic [DATA_W-1:0]              C_data_r
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_e         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0] r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]  r_rsp_data, w_rsp_data_nxt;
    logic               r_c_in_valid, w_c_in_valid_nxt;
    bridge_cmd_t        r_cmd, w_cmd_nxt;

    logic               w_any;
    logic [IDX_W-1:0]   w_win;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_any (w_any),
        .o_idx (w_win)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_gnt_idx_nxt    = r_gnt_idx;
        w_grant_nxt      = '0;
        w_rsp_valid_nxt  = '0;
        w_rsp_data_nxt   = r_rsp_data;
        w_c_in_valid_nxt = 1'b0;
        w_cmd_nxt        = r_cmd;
        unique case (r_state)
            IDLE: begin
                // A completion pulse seen here is a bridge protocol error and is dropped.
                if (w_any) begin
                    w_gnt_idx_nxt    = w_win;
                    w_grant_nxt      = NUM_REQ'(1) << w_win;
                    w_c_in_valid_nxt = 1'b1;
                    w_cmd_nxt.r_wb   = req_r_wb[w_win];
                    w_cmd_nxt.addr   = req_addr[w_win];
                    w_cmd_nxt.data_w = req_data_w[w_win];
                    w_rr_ptr_nxt     = IDX_W'(rr_next(32'(w_win), NUM_REQ));
                    w_state_nxt      = BUSY;
                end
            end
            BUSY: begin
                if (C_out_valid) begin
                    w_rsp_valid_nxt = NUM_REQ'(1) << r_gnt_idx;
                    w_rsp_data_nxt  = r_cmd.r_wb ? C_data_r : '0;
                    w_state_nxt     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_gnt_idx    <= '0;
            r_grant      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_c_in_valid <= 1'b0;
            r_cmd        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_gnt_idx    <= w_gnt_idx_nxt;
            r_grant      <= w_grant_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
            r_c_in_valid <= w_c_in_valid_nxt;
            r_cmd        <= w_cmd_nxt;
        end
    end

    assign req_grant  = r_grant;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign C_in_valid = r_c_in_valid;
    assign C_r_wb     = r_cmd.r_wb;
    assign C_addr     = r_cmd.addr;
    assign C_data_w   = r_cmd.data_w;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Self-checking bench for bridge_arbiter: vector table, directed corner cases, random vs model.
module tb_bridge_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 64;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_r_wb;
    logic [N-1:0][AW-1:0]   req_addr;
    logic [N-1:0][DW-1:0]   req_data_w;
    logic [N-1:0]           req_grant;
    logic [N-1:0]           rsp_valid;
    logic [DW-1:0]          rsp_data;
    logic                   C_in_valid;
    logic                   C_r_wb;
    logic [AW-1:0]          C_addr;
    logic [DW-1:0]          C_data_w;
    logic                   C_out_valid;
    logic [DW-1:0]          C_data_r;

    bridge_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_r_wb    (req_r_wb),
        .req_addr    (req_addr),
        .req_data_w  (req_data_w),
        .req_grant   (req_grant),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .C_in_valid  (C_in_valid),
        .C_r_wb      (C_r_wb),
        .C_addr      (C_addr),
        .C_data_w    (C_data_w),
        .C_out_valid (C_out_valid),
        .C_data_r    (C_data_r)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic        r_wb;
        logic [7:0]  addr;
        logic [63:0] wdata;
        int          lat;
        logic [63:0] bdata;
        logic [1:0]  exp_grant;
        logic [63:0] exp_rsp_data;
    } vec_t;

    vec_t vecs[4];

    // Reference model state for the random phase
    logic [N-1:0]  m_pend;
    logic [N-1:0]  m_rwb;
    logic [AW-1:0] m_addr[N];
    logic [DW-1:0] m_wd[N];
    bit            m_busy;
    bit            m_cur_rwb;
    int            m_owner;
    int            m_ptr;
    int            m_win;
    bit            b_out;
    int            b_cnt;
    logic          cout;
    logic [DW-1:0] cdata;
    logic [N-1:0]  exp_grant;
    logic [N-1:0]  exp_rsp_v;
    logic          exp_cin;
    logic [DW-1:0] exp_rsp_d;
    logic          exp_rwb;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, 128'({req_grant, rsp_valid, C_in_valid, C_r_wb, C_addr}), 128'(0));
        check({name, "_cdata"}, 128'(C_data_w), 128'(0));
        check({name, "_rdata"}, 128'(rsp_data), 128'(0));
    endtask

    task automatic clear_inputs();
        req_valid   = '0;
        req_r_wb    = '0;
        req_addr    = '0;
        req_data_w  = '0;
        C_out_valid = 1'b0;
        C_data_r    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_req(input int id, input logic rwb, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        req_valid[id]  = 1'b1;
        req_r_wb[id]   = rwb;
        req_addr[id]   = a;
        req_data_w[id] = d;
    endtask

    // Called at the negedge of the C_in_valid cycle; returns at the negedge of the rsp cycle.
    task automatic complete(input int lat, input logic [DW-1:0] d);
        repeat (lat) @(negedge clk);
        C_out_valid = 1'b1;
        C_data_r    = d;
        @(negedge clk);
        C_out_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1, 1'b1, 8'h2A, 64'h0, 3, 64'hDEAD_BEEF_0000_0001, 2'b10,
                    64'hDEAD_BEEF_0000_0001};
        vecs[1] = '{0, 1'b0, 8'h10, 64'h55, 1, 64'h1234_5678, 2'b01, 64'h0};
        vecs[2] = '{1, 1'b0, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10,
                    64'h0};
        vecs[3] = '{0, 1'b1, 8'h00, 64'h0, 5, 64'h0123_4567_89AB_CDEF, 2'b01,
                    64'h0123_4567_89AB_CDEF};

        // Reset and idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            check_all_zero("idle");
            @(negedge clk);
        end

        // Single-transaction vector table
        for (int i = 0; i < 4; i++) begin
            req_valid = '0;
            drive_req(vecs[i].id, vecs[i].r_wb, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            check("vec_grant", 128'(req_grant), 128'(vecs[i].exp_grant));
            check("vec_cin", 128'(C_in_valid), 128'(1));
            check("vec_cmd", 128'({C_r_wb, C_addr}), 128'({vecs[i].r_wb, vecs[i].addr}));
            check("vec_cwd", 128'(C_data_w), 128'(vecs[i].wdata));
            req_valid = '0;
            @(negedge clk);
            check("vec_cin_pulse", 128'({C_in_valid, req_grant}), 128'(0));
            complete(vecs[i].lat - 1, vecs[i].bdata);
            check("vec_rsp_valid", 128'(rsp_valid), 128'(vecs[i].exp_grant));
            check("vec_rsp_data", 128'(rsp_data), 128'(vecs[i].exp_rsp_data));
            @(negedge clk);
            check("vec_rsp_pulse", 128'(rsp_valid), 128'(0));
            check("vec_rsp_hold", 128'(rsp_data), 128'(vecs[i].exp_rsp_data));
        end

        // Simultaneous requests, back-to-back grants, third round
        do_reset();
        drive_req(0, 1'b0, 8'h10, 64'h55);
        drive_req(1, 1'b1, 8'h11, 64'h0);
        @(negedge clk);
        check("sim_g1", 128'(req_grant), 128'(2'b01));
        check("sim_g1_cmd", 128'({C_r_wb, C_addr, C_data_w}), 128'({1'b0, 8'h10, 64'h55}));
        req_valid[0] = 1'b0;
        complete(2, 64'h777);
        check("sim_rsp1", 128'({rsp_valid, req_grant}), 128'({2'b01, 2'b00}));
        check("sim_rsp1_data", 128'(rsp_data), 128'(0));
        @(negedge clk);
        check("sim_g2", 128'(req_grant), 128'(2'b10));
        check("sim_g2_cmd", 128'({C_in_valid, C_r_wb, C_addr}), 128'({1'b1, 1'b1, 8'h11}));
        req_valid[1] = 1'b0;
        complete(1, 64'hCAFE);
        check("sim_rsp2", 128'({rsp_valid, rsp_data}), 128'({2'b10, 64'hCAFE}));
        drive_req(0, 1'b1, 8'h20, 64'h0);
        drive_req(1, 1'b0, 8'h21, 64'h3);
        @(negedge clk);
        check("sim_g3", 128'(req_grant), 128'(2'b01));
        req_valid[0] = 1'b0;
        complete(1, 64'hBEEF);
        check("sim_rsp3", 128'({rsp_valid, rsp_data}), 128'({2'b01, 64'hBEEF}));
        @(negedge clk);
        check("sim_g4", 128'(req_grant), 128'(2'b10));
        req_valid[1] = 1'b0;
        complete(1, 64'h9);
        check("sim_rsp4", 128'({rsp_valid, rsp_data}), 128'({2'b10, 64'h0}));

        // Starvation: req0 never lets go
        do_reset();
        drive_req(0, 1'b1, 8'h40, 64'h0);
        @(negedge clk);
        check("starve_g1", 128'(req_grant), 128'(2'b01));
        drive_req(1, 1'b0, 8'h41, 64'h1);
        complete(1, 64'h1);
        @(negedge clk);
        check("starve_g2", 128'(req_grant), 128'(2'b10));
        req_valid[1] = 1'b0;
        complete(1, 64'h2);
        @(negedge clk);
        check("starve_g3", 128'(req_grant), 128'(2'b01));
        complete(1, 64'h5A5A);
        @(negedge clk);
        check("starve_g4", 128'(req_grant), 128'(2'b01));
        req_valid = '0;
        complete(1, 64'hC0DE);
        check("starve_rsp4", 128'({rsp_valid, rsp_data}), 128'({2'b01, 64'hC0DE}));

        // Spurious completion while idle
        @(negedge clk);
        C_out_valid = 1'b1;
        C_data_r    = 64'hBAD;
        @(negedge clk);
        C_out_valid = 1'b0;
        check("spurious_rsp", 128'({rsp_valid, req_grant, C_in_valid}), 128'(0));
        check("spurious_hold", 128'(rsp_data), 128'(64'hC0DE));
        drive_req(1, 1'b1, 8'h42, 64'h0);
        @(negedge clk);
        check("post_spurious_grant", 128'({req_grant, C_addr}), 128'({2'b10, 8'h42}));
        req_valid = '0;
        complete(2, 64'h1111_2222_3333_4444);
        check("post_spurious_rsp", 128'({rsp_valid, rsp_data}),
              128'({2'b10, 64'h1111_2222_3333_4444}));

        // Reset while busy
        drive_req(0, 1'b0, 8'h77, 64'h99);
        @(negedge clk);
        check("rb_grant", 128'({req_grant, C_addr}), 128'({2'b01, 8'h77}));
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_busy");
        @(negedge clk);
        rst_n = 1'b1;
        drive_req(0, 1'b1, 8'h50, 64'h0);
        drive_req(1, 1'b1, 8'h51, 64'h0);
        @(negedge clk);
        check("reset_ptr", 128'({req_grant, C_addr}), 128'({2'b01, 8'h50}));
        req_valid[0] = 1'b0;
        complete(1, 64'h7);
        check("reset_rsp", 128'({rsp_valid, rsp_data}), 128'({2'b01, 64'h7}));
        @(negedge clk);
        check("reset_g2", 128'(req_grant), 128'(2'b10));
        req_valid = '0;
        complete(1, 64'h8);
        check("reset_rsp2", 128'({rsp_valid, rsp_data}), 128'({2'b10, 64'h8}));

        // Random traffic against the reference model
        do_reset();
        m_pend    = '0;
        m_rwb     = '0;
        m_busy    = 1'b0;
        m_cur_rwb = 1'b0;
        m_owner   = 0;
        m_ptr     = 0;
        b_out     = 1'b0;
        b_cnt     = 0;
        exp_grant = '0;
        exp_rsp_v = '0;
        exp_cin   = 1'b0;
        exp_rsp_d = '0;
        exp_rwb   = 1'b0;
        exp_addr  = '0;
        exp_wd    = '0;
        for (int i = 0; i < N; i++) begin
            m_addr[i] = '0;
            m_wd[i]   = '0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            check("rnd_grant", 128'(req_grant), 128'(exp_grant));
            check("rnd_cin", 128'(C_in_valid), 128'(exp_cin));
            check("rnd_rsp_valid", 128'(rsp_valid), 128'(exp_rsp_v));
            check("rnd_rsp_data", 128'(rsp_data), 128'(exp_rsp_d));
            check("rnd_cmd", 128'({C_r_wb, C_addr, C_data_w}), 128'({exp_rwb, exp_addr, exp_wd}));

            // Bridge: one command at a time, 1..4 cycles of latency
            cout  = 1'b0;
            cdata = {$urandom, $urandom};
            if (exp_cin) begin
                b_out = 1'b1;
                b_cnt = int'($urandom_range(1, 4));
            end else if (b_out) begin
                b_cnt--;
                if (b_cnt == 0) begin
                    cout  = 1'b1;
                    b_out = 1'b0;
                end
            end else if (!m_busy && $urandom_range(0, 9) == 0) begin
                cout = 1'b1;
            end

            for (int i = 0; i < N; i++) begin
                if (!m_pend[i] && $urandom_range(0, 2) == 0) begin
                    m_pend[i] = 1'b1;
                    m_rwb[i]  = 1'($urandom);
                    m_addr[i] = AW'($urandom);
                    m_wd[i]   = {$urandom, $urandom};
                end
                req_r_wb[i]   = m_rwb[i];
                req_addr[i]   = m_addr[i];
                req_data_w[i] = m_wd[i];
            end
            req_valid   = m_pend;
            C_out_valid = cout;
            C_data_r    = cdata;

            exp_grant = '0;
            exp_cin   = 1'b0;
            exp_rsp_v = '0;
            if (m_busy) begin
                if (cout) begin
                    exp_rsp_v = N'(1) << m_owner;
                    exp_rsp_d = m_cur_rwb ? cdata : '0;
                    m_busy    = 1'b0;
                end
            end else if (m_pend != '0) begin
                m_win = -1;
                for (int k = 0; k < N; k++) begin
                    if (m_win < 0 && m_pend[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
                end
                exp_grant      = N'(1) << m_win;
                exp_cin        = 1'b1;
                exp_rwb        = m_rwb[m_win];
                exp_addr       = m_addr[m_win];
                exp_wd         = m_wd[m_win];
                m_cur_rwb      = m_rwb[m_win];
                m_owner        = m_win;
                m_ptr          = (m_win + 1) % N;
                m_busy         = 1'b1;
                m_pend[m_win]  = 1'b0;
            end
            @(negedge clk);
        end

        clear_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
